// File: rtl/ddr_word_aligner.sv
// Word aligner for a 2-bit IDDR stream: finds SYNC_WORD at either bit offset,
// confirms it LOCK_COUNT times on word slots, then emits one aligned word per slot.
module ddr_word_aligner #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hA5),
    parameter int              LOCK_COUNT = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             q0_i,
    input  logic             q1_i,
    input  logic             realign_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             offset_o
);

    localparam int             HALF     = WIDTH / 2;
    localparam int             PH_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PH_W-1:0] PH_MAX  = PH_W'(HALF - 1);
    localparam logic [3:0]     CNT_LOCK = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   h_q, h_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             offset_q, offset_d;

    logic [WIDTH-1:0] win0_s, win1_s, sel_win_s, hit_win_s;
    logic             hit0_s, hit1_s, hit_s, slot_s;
    logic [PH_W-1:0]  ph_next_s;
    logic [3:0]       cnt_inc_s;

    // Alignment windows, match detection and phase/count increments.
    always_comb begin
        win0_s    = h_q[WIDTH-1:0];
        win1_s    = h_q[WIDTH:1];
        sel_win_s = offset_q ? win1_s : win0_s;
        hit0_s    = (win0_s == SYNC_WORD);
        hit1_s    = (win1_s == SYNC_WORD);
        hit_s     = hit0_s | hit1_s;
        // Offset 0 takes precedence when both windows match.
        hit_win_s = hit0_s ? win0_s : win1_s;
        slot_s    = (ph_q == {PH_W{1'b0}});
        ph_next_s = (ph_q == PH_MAX) ? {PH_W{1'b0}} : ph_q + PH_W'(1);
        cnt_inc_s = cnt_q + 4'd1;
    end

    // Next-state and output computation for the HUNT/VERIFY/LOCKED sequencer.
    always_comb begin
        h_d      = {h_q[WIDTH-2:0], q0_i, q1_i};
        state_d  = state_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        offset_d = offset_q;

        case (state_q)
            ST_HUNT: begin
                if (hit_s) begin
                    // The hit cycle itself is slot 0 of the new word grid.
                    offset_d = ~hit0_s;
                    ph_d     = PH_W'(1);
                    cnt_d    = 4'd1;
                    if (CNT_LOCK == 4'd1) begin
                        state_d = ST_LOCKED;
                        valid_d = 1'b1;
                        word_d  = hit_win_s;
                    end else begin
                        state_d = ST_VERIFY;
                    end
                end else begin
                    state_d = ST_HUNT;
                    ph_d    = {PH_W{1'b0}};
                    cnt_d   = 4'd0;
                end
            end
            ST_VERIFY: begin
                ph_d = ph_next_s;
                if (slot_s) begin
                    if (sel_win_s == SYNC_WORD) begin
                        cnt_d = cnt_inc_s;
                        if (cnt_inc_s == CNT_LOCK) begin
                            state_d = ST_LOCKED;
                            valid_d = 1'b1;
                            word_d  = sel_win_s;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        cnt_d   = 4'd0;
                        ph_d    = {PH_W{1'b0}};
                    end
                end else begin
                    state_d = ST_VERIFY;
                end
            end
            ST_LOCKED: begin
                ph_d = ph_next_s;
                if (slot_s) begin
                    valid_d = 1'b1;
                    word_d  = sel_win_s;
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_HUNT;
                ph_d    = {PH_W{1'b0}};
                cnt_d   = 4'd0;
            end
        endcase

        // Realign wins over any hit or lock completion computed above.
        if (realign_i) begin
            state_d  = ST_HUNT;
            cnt_d    = 4'd0;
            ph_d     = {PH_W{1'b0}};
            valid_d  = 1'b0;
            word_d   = word_q;
            offset_d = offset_q;
        end else begin
            state_d  = state_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State, history and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_HUNT;
            h_q      <= {(WIDTH+1){1'b0}};
            ph_q     <= {PH_W{1'b0}};
            cnt_q    <= 4'd0;
            word_q   <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            offset_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            offset_q <= offset_d;
        end
    end

    assign word_o   = word_q;
    assign valid_o  = valid_q;
    assign locked_o = locked_q;
    assign offset_o = offset_q;

endmodule

// File: tb/tb_ddr_word_aligner.sv
// Directed bench: two aligners (LOCK_COUNT 3 and 1) share one bit stream.
module tb_ddr_word_aligner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i = 1'b1;
    logic       q0_i = 1'b0;
    logic       q1_i = 1'b0;
    logic       realign_i = 1'b0;
    logic [7:0] word_a, word_b;
    logic       valid_a, locked_a, offset_a;
    logic       valid_b, locked_b, offset_b;

    ddr_word_aligner #(.WIDTH(8), .SYNC_WORD(8'hA5), .LOCK_COUNT(3)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .q0_i(q0_i), .q1_i(q1_i), .realign_i(realign_i),
        .word_o(word_a), .valid_o(valid_a), .locked_o(locked_a), .offset_o(offset_a)
    );

    ddr_word_aligner #(.WIDTH(8), .SYNC_WORD(8'hA5), .LOCK_COUNT(1)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .q0_i(q0_i), .q1_i(q1_i), .realign_i(realign_i),
        .word_o(word_b), .valid_o(valid_b), .locked_o(locked_b), .offset_o(offset_b)
    );

    int         checks = 0;
    int         errors = 0;
    int         vcount = 0;
    logic       locked_seen = 1'b0;
    logic [7:0] vwords[$];
    logic [63:0] stream_v = 64'd0;
    int         bit_pos = 0;
    logic [7:0] exp_words[4];

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (valid_a) begin
            vcount++;
            vwords.push_back(word_a);
        end
        if (locked_a) locked_seen = 1'b1;
    endtask

    task automatic send_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            q0_i = stream_v[63 - bit_pos];
            q1_i = stream_v[62 - bit_pos];
            bit_pos += 2;
            step();
        end
    endtask

    task automatic load(input logic [63:0] s);
        stream_v    = s;
        bit_pos     = 0;
        vcount      = 0;
        locked_seen = 1'b0;
        vwords.delete();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        q0_i  = 1'b0;
        q1_i  = 1'b0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_val("rst_word_a", word_a, 16'h0);
        check_val("rst_valid_a", valid_a, 16'h0);
        check_val("rst_locked_a", locked_a, 16'h0);
        check_val("rst_offset_a", offset_a, 16'h0);
        check_val("rst_word_b", word_b, 16'h0);
        check_val("rst_locked_b", locked_b, 16'h0);

        // Aligned A5 stream; LOCK_COUNT=1 locks on edge 5, LOCK_COUNT=3 on edge 13
        load({8{8'hA5}});
        send_pairs(4);
        check_val("lc1_pre_lock", locked_b, 16'h0);
        send_pairs(1);
        check_val("lc1_locked", locked_b, 16'h1);
        check_val("lc1_valid", valid_b, 16'h1);
        check_val("lc1_word", word_b, 16'hA5);
        send_pairs(7);
        check_val("a0_pre_lock", locked_a, 16'h0);
        check_val("a0_no_valid", vcount, 16'd0);
        send_pairs(1);
        check_val("a0_locked", locked_a, 16'h1);
        check_val("a0_valid", valid_a, 16'h1);
        check_val("a0_word", word_a, 16'hA5);
        check_val("a0_offset", offset_a, 16'h0);
        send_pairs(7);
        check_val("a0_cadence", vcount, 16'd2);
        check_val("a0_nonslot_valid", valid_a, 16'h0);

        // Stream delayed by one bit locks at offset 1 on edge 14
        do_reset();
        load({1'b0, {7{8'hA5}}, 7'b0});
        send_pairs(13);
        check_val("a1_pre_lock", locked_a, 16'h0);
        send_pairs(1);
        check_val("a1_locked", locked_a, 16'h1);
        check_val("a1_valid", valid_a, 16'h1);
        check_val("a1_word", word_a, 16'hA5);
        check_val("a1_offset", offset_a, 16'h1);

        // Reset mid-word while locked, then a full relock
        send_pairs(2);
        rst_i = 1'b1;
        send_pairs(1);
        rst_i = 1'b0;
        check_val("mid_rst_word", word_a, 16'h0);
        check_val("mid_rst_valid", valid_a, 16'h0);
        check_val("mid_rst_locked", locked_a, 16'h0);
        check_val("mid_rst_offset", offset_a, 16'h0);
        check_val("mid_rst_locked_b", locked_b, 16'h0);
        load({{6{8'hA5}}, 16'h0});
        send_pairs(12);
        check_val("relock_pre", locked_a, 16'h0);
        send_pairs(1);
        check_val("relock_locked", locked_a, 16'h1);
        check_val("relock_word", word_a, 16'hA5);

        // A5 A5 3C fails verification, then the following A5 x3 locks
        do_reset();
        load({8'hA5, 8'hA5, 8'h3C, 8'hA5, 8'hA5, 8'hA5, 16'h0});
        send_pairs(24);
        check_val("bad_never_locked", locked_seen, 16'h0);
        check_val("bad_never_valid", vcount, 16'd0);
        send_pairs(1);
        check_val("bad_relock", locked_a, 16'h1);
        check_val("bad_relock_valid", valid_a, 16'h1);

        // Payload after lock, then realign on a slot cycle
        do_reset();
        load({{3{8'hA5}}, 8'h00, 8'hFF, 8'h12, 16'h0});
        send_pairs(25);
        check_val("pay_count", vcount, 16'd4);
        exp_words[0] = 8'hA5;
        exp_words[1] = 8'h00;
        exp_words[2] = 8'hFF;
        exp_words[3] = 8'h12;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("pay_word%0d", i),
                      (i < vwords.size()) ? {8'h00, vwords[i]} : 16'hDEAD,
                      {8'h00, exp_words[i]});
        end
        send_pairs(3);
        realign_i = 1'b1;
        send_pairs(1);
        realign_i = 1'b0;
        check_val("realign_locked", locked_a, 16'h0);
        check_val("realign_valid", valid_a, 16'h0);
        check_val("realign_word_hold", word_a, 16'h12);
        send_pairs(3);
        check_val("realign_stays_hunt", locked_a, 16'h0);
        check_val("realign_no_more_valid", vcount, 16'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_word_aligner.md
DDR_WORD_ALIGNER -- requirements
Module: ddr_word_aligner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning output word width; even, 4..16.
REQ-002 SHALL have parameter SYNC_WORD, default 8'hA5 (WIDTH bits), meaning the alignment pattern; nonzero.
REQ-003 SHALL have parameter LOCK_COUNT, default 3, meaning consecutive sync words required to lock; 1..15.
REQ-004 SHALL have port clk_i, input, 1, the DDR sampling clock that also clocks the upstream IDDR; single clock domain.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port q0_i, input, 1, earlier bit of the IDDR pair (rising-edge sample).
REQ-007 SHALL have port q1_i, input, 1, later bit of the IDDR pair (falling-edge sample).
REQ-008 SHALL have port realign_i, input, 1, synchronous request to drop lock and re-hunt.
REQ-009 SHALL have port word_o, output, WIDTH, aligned word, MSB = first-received bit.
REQ-010 SHALL have port valid_o, output, 1, one-cycle strobe qualifying word_o.
REQ-011 SHALL have port locked_o, output, 1, high while in LOCKED.
REQ-012 SHALL have port offset_o, output, 1, selected bit offset (0 or 1) within the 2-bit pair.

Function
REQ-013 History register h (WIDTH+1 bits) SHALL shift by 2 per cycle: h <= {h[WIDTH-2:0], q0_i, q1_i}.
REQ-014 Window W0 = h[WIDTH-1:0] and window W1 = h[WIDTH:1]; together with phase counter these SHALL cover all WIDTH bit alignments.
REQ-015 Phase counter ph SHALL count 0..WIDTH/2-1, wrapping; cycles with ph==0 in VERIFY/LOCKED are slot cycles.
REQ-016 States SHALL be HUNT, VERIFY, LOCKED.
REQ-017 HUNT: if W0==SYNC_WORD, offset<=0; else if W1==SYNC_WORD, offset<=1; W0 wins when both match.
REQ-018 HUNT hit: ph<=1 (WIDTH/2==... hit cycle counts as slot ph=0), match count<=1; go VERIFY, or LOCKED directly if LOCK_COUNT==1.
REQ-019 VERIFY slot: window[offset]==SYNC_WORD -> count+1, go LOCKED when count+1==LOCK_COUNT; mismatch -> HUNT, count<=0.
REQ-020 LOCKED slot: word_o<=window[offset] and valid_o<=1 on the next edge, regardless of content; non-slot cycles valid_o<=0.
REQ-021 Slot word completing lock (VERIFY->LOCKED, or HUNT->LOCKED with LOCK_COUNT==1) SHALL itself be emitted with valid_o=1.
REQ-022 valid_o SHALL never assert in HUNT or on VERIFY slots that do not complete lock; word_o holds its last value when valid_o=0.
REQ-023 Latency: word_o/valid_o SHALL update on the edge after the slot cycle, i.e. 1 cycle after the word's last bit enters h.
REQ-024 In LOCKED, valid_o SHALL assert exactly once every WIDTH/2 cycles.
REQ-025 locked_o SHALL be registered, high in LOCKED; offset_o SHALL reflect the offset latched on the last HUNT hit.
REQ-026 realign_i=1 SHALL force HUNT, count<=0, ph<=0, locked_o<=0, valid_o<=0 on the next edge; h continues shifting; realign_i overrides a simultaneous HUNT hit or lock completion.
REQ-027 No sync-loss detection in LOCKED; only realign_i or rst_i leaves LOCKED.

Reset
REQ-028 rst_i=1 SHALL on the next edge set h=0, ph=0, count=0, state=HUNT, word_o=0, valid_o=0, locked_o=0, offset_o=0.
REQ-029 rst_i SHALL take priority over realign_i and all state transitions, including mid-word and mid-VERIFY.
REQ-030 After reset, lock SHALL require a fresh HUNT hit plus the full LOCK_COUNT sequence.

Verification (WIDTH=8, SYNC_WORD=8'hA5, LOCK_COUNT=3 unless noted)
REQ-031 Repeated A5 aligned to pair boundary -> locked_o=1 after third sync word, offset_o=0, valid_o every 4 cycles, word_o=8'hA5.
REQ-032 Same stream delayed by one bit -> offset_o=1, locked, word_o=8'hA5.
REQ-033 A5, A5, 3C -> return to HUNT after 3C slot, locked_o never 1, valid_o never 1.
REQ-034 Lock then payload 00,FF,12 -> valid_o with word_o=00,FF,12 in order; realign_i pulse -> locked_o=0 and valid_o=0 next cycle.
REQ-035 rst_i asserted mid-word while locked -> all outputs 0 next edge; relock needs three A5 words.
REQ-036 LOCK_COUNT=1, single A5 -> locked_o=1 and valid_o with word_o=8'hA5 on the edge after the hit.
